// File: rtl/gt_link_reset_ctrl.sv
// GT link bring-up sequencer: TX then RX reset pulses, reset-done waits, lane
// settle qualification, link-drop debounce and bounded RX retries.
module gt_link_reset_ctrl #(
  parameter int NUM_LANES        = 4,
  parameter int RST_PULSE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES   = 67108864,
  parameter int SETTLE_CYCLES    = 1048576,
  parameter int DEBOUNCE_CYCLES  = 8,
  parameter int MAX_RETRY        = 4,
  parameter int CNT_W            = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 force_reinit,
  input  logic                 tx_reset_done,
  input  logic                 rx_reset_done,
  input  logic [NUM_LANES-1:0] rx_status,
  output logic                 gtwiz_tx_reset,
  output logic                 gtwiz_rx_reset,
  output logic                 channel_up,
  output logic                 user_reset,
  output logic [2:0]           retry_cnt,
  output logic [7:0]           link_drop_cnt
);

  typedef enum logic [5:0] {
    TX_RST  = 6'b000001,
    TX_WAIT = 6'b000010,
    RX_RST  = 6'b000100,
    RX_WAIT = 6'b001000,
    SETTLE  = 6'b010000,
    UP      = 6'b100000
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [2:0]       RETRY_LAST   = 3'(MAX_RETRY - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] stab_r, stab_s;
  logic [2:0]       retry_r, retry_s;
  logic [7:0]       drop_r, drop_s;
  logic             all_good_s;
  logic             timeout_s;
  state_t           retry_state_s;
  logic [2:0]       retry_next_s;

  assign all_good_s    = &rx_status;
  assign timeout_s     = (cnt_r == TIMEOUT_LAST);
  // A retry either re-pulses RX or, once the budget is spent, escalates to a full re-init.
  assign retry_state_s = (retry_r == RETRY_LAST) ? TX_RST : RX_RST;
  assign retry_next_s  = (retry_r == RETRY_LAST) ? 3'd0 : (retry_r + 3'd1);

  // Next-state and counter update logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    stab_s  = stab_r;
    retry_s = retry_r;
    drop_s  = drop_r;
    if (force_reinit) begin
      state_s = TX_RST;
      retry_s = 3'd0;
    end else begin
      case (state_r)
        TX_RST: begin
          if (cnt_r == PULSE_LAST) state_s = TX_WAIT;
          else                     state_s = TX_RST;
        end
        TX_WAIT: begin
          if (tx_reset_done)  state_s = RX_RST;
          else if (timeout_s) state_s = TX_RST;
          else                state_s = TX_WAIT;
        end
        RX_RST: begin
          if (cnt_r == PULSE_LAST) state_s = RX_WAIT;
          else                     state_s = RX_RST;
        end
        RX_WAIT: begin
          if (rx_reset_done) begin
            state_s = SETTLE;
          end else if (timeout_s) begin
            state_s = retry_state_s;
            retry_s = retry_next_s;
          end else begin
            state_s = RX_WAIT;
          end
        end
        SETTLE: begin
          if (all_good_s && (stab_r == SETTLE_LAST)) begin
            state_s = UP;
            retry_s = 3'd0;
          end else if (timeout_s) begin
            state_s = retry_state_s;
            retry_s = retry_next_s;
          end else if (all_good_s) begin
            stab_s = stab_r + CNT_ONE;
          end else begin
            stab_s = '0;
          end
        end
        UP: begin
          if (all_good_s) begin
            stab_s = '0;
          end else if (stab_r == DEB_LAST) begin
            state_s = RX_RST;
            if (drop_r == 8'hFF) drop_s = drop_r;
            else                 drop_s = drop_r + 8'd1;
          end else begin
            stab_s = stab_r + CNT_ONE;
          end
        end
        default: begin
          state_s = TX_RST;
          retry_s = 3'd0;
        end
      endcase
    end
    // Force restarts the pulse even when the state itself does not change.
    if (force_reinit || (state_s != state_r)) begin
      cnt_s  = '0;
      stab_s = '0;
    end else if (state_r == UP) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= TX_RST;
      cnt_r   <= '0;
      stab_r  <= '0;
      retry_r <= 3'd0;
      drop_r  <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      stab_r  <= stab_s;
      retry_r <= retry_s;
      drop_r  <= drop_s;
    end
  end

  assign gtwiz_tx_reset = (state_r == TX_RST);
  assign gtwiz_rx_reset = (state_r == TX_RST) || (state_r == RX_RST);
  assign channel_up     = (state_r == UP);
  assign user_reset     = (state_r != UP);
  assign retry_cnt      = retry_r;
  assign link_drop_cnt  = drop_r;

endmodule

// File: tb/tb_gt_link_reset_ctrl.sv
// Directed self-checking bench for gt_link_reset_ctrl using small test-plan parameters.
module tb_gt_link_reset_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       force_reinit;
  logic       tx_reset_done;
  logic       rx_reset_done;
  logic [3:0] rx_status;
  logic       gtwiz_tx_reset;
  logic       gtwiz_rx_reset;
  logic       channel_up;
  logic       user_reset;
  logic [2:0] retry_cnt;
  logic [7:0] link_drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  gt_link_reset_ctrl #(
    .NUM_LANES(4), .RST_PULSE_CYCLES(4), .TIMEOUT_CYCLES(32), .SETTLE_CYCLES(16),
    .DEBOUNCE_CYCLES(3), .MAX_RETRY(3), .CNT_W(27)
  ) dut (
    .clk(clk), .reset(reset), .force_reinit(force_reinit),
    .tx_reset_done(tx_reset_done), .rx_reset_done(rx_reset_done), .rx_status(rx_status),
    .gtwiz_tx_reset(gtwiz_tx_reset), .gtwiz_rx_reset(gtwiz_rx_reset),
    .channel_up(channel_up), .user_reset(user_reset),
    .retry_cnt(retry_cnt), .link_drop_cnt(link_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at index 0 of a fresh TX_RST pulse.
  task automatic do_force();
    force_reinit = 1'b1;
    tick();
    force_reinit = 1'b0;
  endtask

  task automatic wait_up(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (channel_up) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic count_tx(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (gtwiz_tx_reset) cnt++;
      tick();
    end
  endtask

  // Bring-up with rx_status low at indices [g0, g0+glen); observe at index obs.
  task automatic run_settle(input string tag, input int g0, input int glen, input int obs,
                            input logic exp_up, input logic exp_rx, input logic [2:0] exp_retry);
    do_force();
    for (int i = 0; i < obs; i++) begin
      rx_status = (i >= g0 && i < g0 + glen) ? 4'hB : 4'hF;
      if (i == obs - 1) check({tag, "_up_before"}, 32'(channel_up), 32'd0);
      tick();
    end
    rx_status = 4'hF;
    check({tag, "_up"}, 32'(channel_up), 32'(exp_up));
    check({tag, "_rx"}, 32'(gtwiz_rx_reset), 32'(exp_rx));
    check({tag, "_retry"}, 32'(retry_cnt), 32'(exp_retry));
  endtask

  initial begin
    int  ntx, nrxo, nrx, up_idx, miss, k;
    bit  ok, prev, rxo, t112, t113;
    logic ur25, ur26;
    logic [2:0] r41, r77, r113;
    int  rises [8];

    reset = 1'b1; force_reinit = 1'b0;
    tx_reset_done = 1'b1; rx_reset_done = 1'b1; rx_status = 4'hF;
    repeat (3) tick();
    check("rst_tx", 32'(gtwiz_tx_reset), 32'd1);
    check("rst_rx", 32'(gtwiz_rx_reset), 32'd1);
    check("rst_up", 32'(channel_up), 32'd0);
    check("rst_user_reset", 32'(user_reset), 32'd1);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_drop", 32'(link_drop_cnt), 32'd0);
    reset = 1'b0;

    // Clean bring-up
    ntx = 0; nrxo = 0; up_idx = -1; ur25 = 1'b0; ur26 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (gtwiz_tx_reset) ntx++;
      if (gtwiz_rx_reset && !gtwiz_tx_reset) nrxo++;
      if (channel_up && up_idx < 0) up_idx = i;
      if (i == 25) ur25 = user_reset;
      if (i == 26) ur26 = user_reset;
      tick();
    end
    check("bringup_tx_width", 32'(ntx), 32'd4);
    check("bringup_rx_only_width", 32'(nrxo), 32'd4);
    check("bringup_up_index", 32'(up_idx), 32'd26);
    check("bringup_user_reset_before", 32'(ur25), 32'd1);
    check("bringup_user_reset_at_up", 32'(ur26), 32'd0);

    // Link drop: a 2-cycle glitch is filtered, a 3-cycle one drops the link
    ok = 1'b1;
    rx_status = 4'hE;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (!channel_up) ok = 1'b0;
    end
    rx_status = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!channel_up) ok = 1'b0;
    end
    check("glitch2_stays_up", 32'(ok), 32'd1);
    rx_status = 4'hE;
    repeat (3) tick();
    rx_status = 4'hF;
    check("drop3_up", 32'(channel_up), 32'd0);
    check("drop3_cnt", 32'(link_drop_cnt), 32'd1);
    check("drop3_tx", 32'(gtwiz_tx_reset), 32'd0);
    nrx = 0;
    for (int i = 0; i < 10; i++) begin
      if (gtwiz_rx_reset) nrx++;
      tick();
    end
    check("drop3_rx_width", 32'(nrx), 32'd4);
    wait_up(40, ok);
    check("drop3_recover", 32'(ok), 32'd1);

    miss = 0;
    for (int d = 0; d < 256; d++) begin
      rx_status = 4'hE;
      repeat (3) tick();
      rx_status = 4'hF;
      wait_up(40, ok);
      if (!ok) miss++;
    end
    check("drops_recover_all", 32'(miss), 32'd0);
    check("drop_cnt_saturate", 32'(link_drop_cnt), 32'd255);

    // force_reinit from UP, then again part-way through TX_RST
    do_force();
    check("force_up_tx", 32'(gtwiz_tx_reset), 32'd1);
    check("force_up_retry", 32'(retry_cnt), 32'd0);
    check("force_up_drop", 32'(link_drop_cnt), 32'd255);
    count_tx(8, ntx);
    check("force_up_tx_width", 32'(ntx), 32'd4);
    do_force();
    repeat (2) tick();
    do_force();
    count_tx(8, ntx);
    check("force_txrst_tx_width", 32'(ntx), 32'd4);
    check("force_txrst_drop", 32'(link_drop_cnt), 32'd255);

    // Settle glitches: restart, success at the timeout cycle, timeout retry
    run_settle("settle_glitch", 20, 1, 37, 1'b1, 1'b0, 3'd0);
    run_settle("settle_edge_win", 25, 1, 42, 1'b1, 1'b0, 3'd0);
    run_settle("settle_timeout", 25, 2, 42, 1'b0, 1'b1, 3'd1);

    // Retry escalation with rx_reset_done stuck low
    rx_reset_done = 1'b0;
    do_force();
    k = 0; prev = 1'b0; r41 = 3'd7; r77 = 3'd7; r113 = 3'd7; t112 = 1'b1; t113 = 1'b0;
    for (int i = 0; i < 8; i++) rises[i] = -1;
    for (int i = 0; i < 120; i++) begin
      rxo = gtwiz_rx_reset && !gtwiz_tx_reset;
      if (rxo && !prev && k < 8) begin
        rises[k] = i;
        k++;
      end
      prev = rxo;
      if (i == 41) r41 = retry_cnt;
      if (i == 77) r77 = retry_cnt;
      if (i == 112) t112 = gtwiz_tx_reset;
      if (i == 113) begin
        t113 = gtwiz_tx_reset;
        r113 = retry_cnt;
      end
      tick();
    end
    check("esc_rise0", 32'(rises[0]), 32'd5);
    check("esc_rise1", 32'(rises[1]), 32'd41);
    check("esc_rise2", 32'(rises[2]), 32'd77);
    check("esc_retry1", 32'(r41), 32'd1);
    check("esc_retry2", 32'(r77), 32'd2);
    check("esc_tx_before", 32'(t112), 32'd0);
    check("esc_tx_pulse", 32'(t113), 32'd1);
    check("esc_retry_cleared", 32'(r113), 32'd0);
    rx_reset_done = 1'b1;

    // TX_WAIT timeout, then done arriving on the timeout cycle wins
    tx_reset_done = 1'b0;
    do_force();
    repeat (35) tick();
    check("txwait_pre_tx", 32'(gtwiz_tx_reset), 32'd0);
    tick();
    check("txwait_timeout_tx", 32'(gtwiz_tx_reset), 32'd1);
    do_force();
    repeat (35) tick();
    tx_reset_done = 1'b1;
    tick();
    check("txwait_win_tx", 32'(gtwiz_tx_reset), 32'd0);
    check("txwait_win_rx", 32'(gtwiz_rx_reset), 32'd1);

    // One-cycle reset while in SETTLE
    do_force();
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_tx", 32'(gtwiz_tx_reset), 32'd1);
    check("midrst_rx", 32'(gtwiz_rx_reset), 32'd1);
    check("midrst_up", 32'(channel_up), 32'd0);
    check("midrst_user_reset", 32'(user_reset), 32'd1);
    check("midrst_retry", 32'(retry_cnt), 32'd0);
    check("midrst_drop", 32'(link_drop_cnt), 32'd0);
    count_tx(8, ntx);
    check("midrst_tx_width", 32'(ntx), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gt_link_reset_ctrl.md
Name: gt_link_reset_ctrl

Overview:
Multi-lane GT link bring-up sequencer. It pulses the transceiver TX reset and then the RX reset, and waits for the reset-done flags. It qualifies that every lane's rx_status is stable before declaring channel_up. It recovers autonomously from timeouts and link drops through bounded RX retries, escalating to a full TX+RX re-init. It sits between the GT wizard reset ports and the user datapath, and drives user_reset to the datapath.

Parameters:
NUM_LANES, 4, number of lanes monitored via rx_status.
RST_PULSE_CYCLES, 64, length of each gtwiz reset pulse in clk cycles (>=2).
TIMEOUT_CYCLES, 67108864, max cycles spent in any wait or settle state before retry.
SETTLE_CYCLES, 1048576, consecutive all-lanes-good cycles required before channel_up.
DEBOUNCE_CYCLES, 8, consecutive cycles with any lane bad (while up) before declaring link drop.
MAX_RETRY, 4, RX-only retries before escalating to full TX+RX re-init (>=1).
CNT_W, 27, width of the cycle counters; must hold TIMEOUT_CYCLES-1.

Ports:
clk  in  1  single system clock
reset  in  1  synchronous, active-high reset
force_reinit  in  1  single-cycle request for a full re-init (TX+RX)
tx_reset_done  in  1  GT TX reset complete, level
rx_reset_done  in  1  GT RX reset complete, level
rx_status  in  NUM_LANES  per-lane RX good (aligned/locked), level
gtwiz_tx_reset  out  1  GT TX reset request
gtwiz_rx_reset  out  1  GT RX reset request
channel_up  out  1  link qualified and usable
user_reset  out  1  datapath reset, equal to ~channel_up
retry_cnt  out  3  current RX retry count
link_drop_cnt  out  8  saturating count of link drops seen while up

Behaviour:
- One-hot state register holding the states TX_RST, TX_WAIT, RX_RST, RX_WAIT, SETTLE, UP. Outputs are combinational decodes of the state register:
  - gtwiz_tx_reset = TX_RST.
  - gtwiz_rx_reset = TX_RST | RX_RST.
  - channel_up = UP.
- Reset values: state=TX_RST, all counters=0, retry_cnt=0, link_drop_cnt=0. During and immediately after reset: gtwiz_tx_reset=1, gtwiz_rx_reset=1, channel_up=0, user_reset=1.
- Counters: cnt is the pulse/timeout counter and is cleared on every state change. stab is the settle/debounce counter.
- TX_RST: cnt++ each cycle; at cnt==RST_PULSE_CYCLES-1 go to TX_WAIT. The pulse is exactly RST_PULSE_CYCLES cycles after reset deasserts.
- TX_WAIT: if tx_reset_done -> RX_RST; else if cnt==TIMEOUT_CYCLES-1 -> TX_RST. Success wins over timeout in the same cycle.
- RX_RST: RST_PULSE_CYCLES-cycle pulse, then go to RX_WAIT.
- RX_WAIT: if rx_reset_done -> SETTLE with stab=0; on timeout -> RETRY.
- SETTLE: if &rx_status, stab++, else stab=0. At stab==SETTLE_CYCLES-1 with &rx_status high -> UP. Otherwise, if cnt==TIMEOUT_CYCLES-1 -> RETRY. Success wins over timeout.
- RETRY is an action, not a state:
  - if retry_cnt==MAX_RETRY-1: go to TX_RST and clear retry_cnt;
  - else: go to RX_RST and retry_cnt++.
- UP: entering UP clears retry_cnt and stab. While up, stab++ when any lane is low and stab=0 when all lanes are high. At stab==DEBOUNCE_CYCLES-1 with a lane still low:
  - go to RX_RST;
  - link_drop_cnt++, saturating at 255.
  A glitch shorter than DEBOUNCE_CYCLES does not drop channel_up.
- rx_reset_done deasserting in UP is ignored; only rx_status is monitored.
- force_reinit: evaluated in every state and takes priority over all transitions except reset. It forces TX_RST with cnt, stab and retry_cnt cleared; link_drop_cnt is kept. A force_reinit asserted during TX_RST restarts the pulse count.
- Illegal or non-one-hot state: go to TX_RST on the next cycle.
- Reset asserted mid-sequence: state returns to TX_RST the following cycle and link_drop_cnt clears.
- No combinational path from inputs to outputs.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, TIMEOUT_CYCLES=32, SETTLE_CYCLES=16, DEBOUNCE_CYCLES=3, MAX_RETRY=3, NUM_LANES=4.
1. Clean bring-up: release reset with tx_reset_done, rx_reset_done and rx_status=4'hF all tied high.
   - gtwiz_tx_reset is high for exactly 4 cycles, then gtwiz_rx_reset is high for 4 more cycles.
   - channel_up rises 16 cycles after entering SETTLE; user_reset falls the same cycle.
2. Settle glitch: drop rx_status[2] for 1 cycle at stab=10 in SETTLE.
   - stab restarts, and channel_up rises 16 cycles after the glitch ends.
   - If the total exceeds 32 cycles, a retry occurs with retry_cnt=1.
3. Retry escalation: hold rx_reset_done=0.
   - RX_RST pulses repeat every 36 cycles, with retry_cnt going 1 and then 2.
   - The third timeout produces a TX_RST pulse and retry_cnt=0.
4. Link drop while up:
   - Drop rx_status[0] for 2 cycles: channel_up stays 1.
   - Drop it for 3 cycles: channel_up falls, gtwiz_rx_reset pulses for 4 cycles, link_drop_cnt=1.
   - Apply 256 such drops: link_drop_cnt saturates at 255.
5. force_reinit during UP and during TX_RST: next cycle is TX_RST, the pulse is exactly 4 cycles, retry_cnt=0, and link_drop_cnt is unchanged.
6. Assert reset for 1 cycle while in SETTLE: the next state is TX_RST with all outputs and counters at their reset values.
